// File: rtl/cosmac_bus_if.sv
// CDP1802 bus slave front end: XCLK/CLEAR generation, control synchronisers, address rebuild, memory requests.
// Optional COSMAC_BUS_WAIT_EN: stall the CPU through cpu_nwait while a memory request is outstanding.
module cosmac_bus_if #(
  parameter int XCLK_HALF    = 4,
  parameter int CLEAR_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        cpu_xclk,
  output logic        cpu_nclear,
  output logic        cpu_nwait,
  input  logic        cpu_nmrd,
  input  logic        cpu_nmwr,
  input  logic        cpu_tpa,
  input  logic        cpu_tpb,
  input  logic [7:0]  cpu_ma,
  input  logic [7:0]  cpu_db_in,
  output logic [7:0]  cpu_db_out,
  output logic        cpu_db_oe,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam int CLR_TOTAL = 2 * XCLK_HALF * CLEAR_CYCLES;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, RD_REQ, RD_DRIVE, WR_WAIT_TPB, WR_REQ, DONE
  } state_t;

  state_t      state, state_d;
  logic [15:0] xclk_cnt;
  logic [15:0] clr_cnt;
  logic [1:0]  mrd_sr;
  logic [2:0]  mwr_sr, tpa_sr, tpb_sr;
  logic        nmrd_s, nmwr_s, tpa_s;
  logic        tpa_rise, tpa_fall, tpb_rise, tpb_fall, mwr_rise;
  logic        abort;
  logic        lat_hi, lat_lo, rd_fire, wr_fire, rd_cap, oe_drop;
  logic        oe_q;
  logic [7:0]  addr_hi;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xclk_cnt <= '0;
      cpu_xclk <= 1'b0;
    end else if (xclk_cnt == 16'(XCLK_HALF - 1)) begin
      xclk_cnt <= '0;
      cpu_xclk <= ~cpu_xclk;
    end else begin
      xclk_cnt <= xclk_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_cnt    <= '0;
      cpu_nclear <= 1'b0;
    end else if (!cpu_nclear) begin
      if (clr_cnt == 16'(CLR_TOTAL - 1))
        cpu_nclear <= 1'b1;
      else
        clr_cnt <= clr_cnt + 16'd1;
    end
  end

  // bit 1 is the synchronised level, bit 2 its previous value for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mrd_sr <= 2'b11;
      mwr_sr <= 3'b111;
      tpa_sr <= 3'b000;
      tpb_sr <= 3'b000;
    end else begin
      mrd_sr <= {mrd_sr[0], cpu_nmrd};
      mwr_sr <= {mwr_sr[1:0], cpu_nmwr};
      tpa_sr <= {tpa_sr[1:0], cpu_tpa};
      tpb_sr <= {tpb_sr[1:0], cpu_tpb};
    end
  end

  assign nmrd_s   = mrd_sr[1];
  assign nmwr_s   = mwr_sr[1];
  assign tpa_s    = tpa_sr[1];
  assign tpa_rise = tpa_sr[1] & ~tpa_sr[2];
  assign tpa_fall = ~tpa_sr[1] & tpa_sr[2];
  assign tpb_rise = tpb_sr[1] & ~tpb_sr[2];
  assign tpb_fall = ~tpb_sr[1] & tpb_sr[2];
  assign mwr_rise = mwr_sr[1] & ~mwr_sr[2];
  assign abort    = tpa_rise && (state != IDLE) && (state != ADDR_HI);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    lat_lo  = 1'b0;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    rd_cap  = 1'b0;
    oe_drop = 1'b0;
    case (state)
      IDLE:        if (tpa_s) state_d = ADDR_HI;
      ADDR_HI:     if (tpa_fall) state_d = ADDR_LO;
      ADDR_LO: begin
        if (!nmrd_s) begin
          lat_lo  = 1'b1;
          rd_fire = 1'b1;
          state_d = RD_REQ;
        end else if (!nmwr_s) begin
          lat_lo  = 1'b1;
          state_d = WR_WAIT_TPB;
        end else if (tpb_fall) begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_ready) begin
          rd_cap  = 1'b1;
          state_d = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (nmrd_s) begin
          oe_drop = 1'b1;
          state_d = IDLE;
        end
      end
      WR_WAIT_TPB: begin
        if (tpb_rise || mwr_rise) begin
          wr_fire = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ:      if (mem_ready) state_d = DONE;
      DONE:        if (nmwr_s && !tpa_s) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    // a new TPA overrides whatever cycle was in flight
    if (abort) begin
      state_d = ADDR_HI;
      lat_lo  = 1'b0;
      rd_fire = 1'b0;
      wr_fire = 1'b0;
      rd_cap  = 1'b0;
      oe_drop = 1'b1;
    end
  end

  assign lat_hi = tpa_s && (state_d == ADDR_HI);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      addr_hi    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_db_out <= '0;
      oe_q       <= 1'b0;
    end else begin
      mem_rd <= rd_fire;
      mem_wr <= wr_fire;
      if (lat_hi)  addr_hi   <= cpu_ma;
      if (lat_lo)  mem_addr  <= {addr_hi, cpu_ma};
      if (wr_fire) mem_wdata <= cpu_db_in;
      if (rd_cap) begin
        cpu_db_out <= mem_rdata;
        oe_q       <= 1'b1;
      end else if (oe_drop) begin
        oe_q <= 1'b0;
      end
    end
  end

  // release the bus in the same clk the strobe goes away, not one later
  assign cpu_db_oe = oe_q & ~oe_drop;

`ifdef COSMAC_BUS_WAIT_EN
  logic wait_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      wait_q <= 1'b0;
    else if (rd_fire || wr_fire)
      wait_q <= 1'b1;
    else if ((((state == RD_REQ) || (state == WR_REQ)) && mem_ready) || abort)
      wait_q <= 1'b0;
  end

  assign cpu_nwait = ~wait_q;
`else
  assign cpu_nwait = 1'b1;
`endif

endmodule

// File: doc/cosmac_bus_if.md
Name: cosmac_bus_if

Overview:
- Slave-side front end between CDP1802 (COSMAC) bus pins and the on-chip memory array.
- Generates the CPU clock (XCLK) and the power-on CLEAR.
- Synchronises the bus controls, rebuilds the 16-bit address from the multiplexed MA pins, and issues single-cycle read/write requests to the memory core.
- Drives DB during memory reads.

Parameters:
- XCLK_HALF, 4: clk cycles per XCLK half-period (16 MHz / 8 = 2 MHz).
- CLEAR_CYCLES, 16: XCLK periods that cpu_nclear stays low after reset release.

Ports:
- clk  in  1  system clock, the 16 MHz board clock.
- resetn  in  1  asynchronous active-low reset.
- cpu_xclk  out  1  CPU clock.
- cpu_nclear  out  1  CPU CLEAR, active low.
- cpu_nwait  out  1  CPU WAIT, active low.
- cpu_nmrd  in  1  memory read strobe, active low.
- cpu_nmwr  in  1  memory write strobe, active low.
- cpu_tpa  in  1  timing pulse A; high address byte is valid on MA while it is high.
- cpu_tpb  in  1  timing pulse B.
- cpu_ma  in  8  multiplexed address.
- cpu_db_in  in  8  data bus, input side.
- cpu_db_out  out  8  data bus drive value.
- cpu_db_oe  out  1  data bus output enable.
- mem_addr  out  16  request address.
- mem_rd  out  1  read request, one-clk pulse.
- mem_wr  out  1  write request, one-clk pulse.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid when mem_ready=1.
- mem_ready  in  1  request complete; may be high in the same cycle as mem_rd/mem_wr.

Behaviour:
- Reset values: cpu_xclk=0, cpu_nclear=0, cpu_nwait=1, cpu_db_oe=0, cpu_db_out=0, mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0. FSM goes to IDLE.
- XCLK: free-running counter; cpu_xclk toggles every XCLK_HALF clk cycles.
- CLEAR: cpu_nclear goes high after CLEAR_CYCLES full XCLK periods following reset release.
- Synchronisers: cpu_nmrd, cpu_nmwr, cpu_tpa and cpu_tpb pass through 2-flop synchronisers. Edges are detected on the synchronised versions. cpu_ma and cpu_db_in are sampled raw, only when qualified by the synchronised controls.
- FSM states: IDLE, ADDR_HI, ADDR_LO, RD_REQ, RD_DRIVE, WR_WAIT_TPB, WR_REQ, DONE.
- IDLE: on synchronised TPA high, go to ADDR_HI.
- ADDR_HI: latch cpu_ma into the high byte every clk while TPA is high. On TPA falling, go to ADDR_LO.
- ADDR_LO:
  - synchronised nMRD low: latch cpu_ma into the low byte, set mem_rd=1 for one clk, go to RD_REQ.
  - else synchronised nMWR low: latch cpu_ma into the low byte, go to WR_WAIT_TPB.
  - else TPB falling with neither strobe seen (non-memory cycle): go to IDLE with no request.
  - nMRD and nMWR both low in the same clk: read wins.
- RD_REQ: on mem_ready, capture mem_rdata into cpu_db_out, set cpu_db_oe=1, go to RD_DRIVE.
- RD_DRIVE: keep driving. On synchronised nMRD high, cpu_db_oe=0 in the same clk; go to IDLE.
- WR_WAIT_TPB: on TPB rising, set mem_wdata=cpu_db_in and mem_wr=1 for one clk, go to WR_REQ. If nMWR rises before TPB, capture at that edge instead.
- WR_REQ: on mem_ready, go to DONE.
- DONE: wait for nMWR high and TPA low, then go to IDLE.
- TPA rising in any state other than IDLE or ADDR_HI: abort the cycle. No pending request is issued, cpu_db_oe=0, go to ADDR_HI. A request already issued is left to complete at the memory side.
- Address is held on mem_addr from the rd/wr pulse until the next ADDR_LO latch.
- Read latency: mem_rd is asserted 3 clk after raw nMRD falls (2 sync + 1). cpu_db_oe rises 1 clk after mem_ready.
- Reset mid-operation: all state cleared immediately (asynchronous). cpu_db_oe drops at once. cpu_nclear is reasserted and the CLEAR count restarts.
- Only one request is outstanding at a time. mem_rd and mem_wr are never high together.

Optional Feature:
- Macro: COSMAC_BUS_WAIT_EN.
- Defined: cpu_nwait is driven low from the clk in which mem_rd or mem_wr is issued until the clk after mem_ready, so the CPU stalls on slow memory.
- Undefined: cpu_nwait is constant 1. Memory must answer within 2 XCLK periods; not checked.

Test Plan:
- Reset then release -> all outputs at reset values; cpu_xclk period 8 clk; cpu_nclear rises after exactly 128 clk.
- Read: MA=0x12 during TPA, MA=0x34 after, nMRD low, mem_ready=1 with mem_rdata=0xA5 -> one mem_rd pulse with mem_addr=0x1234; cpu_db_out=0xA5 and cpu_db_oe=1 until 2 clk after nMRD rises.
- Write: MA=0x00/0x56, nMWR low, DB=0x5A at TPB -> one mem_wr pulse, mem_addr=0x0056, mem_wdata=0x5A; no mem_rd; cpu_db_oe stays 0.
- Non-memory cycle: TPA, then TPB with both strobes high -> no mem_rd or mem_wr; FSM back in IDLE.
- resetn low while cpu_db_oe=1 -> cpu_db_oe=0 asynchronously; cpu_nclear=0; next cycle after release reads correctly.
- With COSMAC_BUS_WAIT_EN, mem_ready delayed 10 clk -> cpu_nwait low for 11 clk starting at the mem_rd pulse. Without the macro -> cpu_nwait stays 1.
